// File: rtl/row_streamer_param.sv
// row_streamer_param: streams a stored RGB row as an Avalon-ST video frame
// with SCALE x SCALE replication, channel widening and a colour-bar mode.
module row_streamer_param #(
  parameter int CH_IN  = 8,
  parameter int CH_OUT = 10,
  parameter int ADDR_W = 9,
  parameter int H_RES  = 320,
  parameter int V_RES  = 240,
  parameter int SCALE  = 1
) (
  input  logic                clock,
  input  logic                reset_reset_n,
  input  logic                enable,
  input  logic                test_mode,
  output logic [ADDR_W-1:0]   rd_addr,
  output logic                rd_en,
  input  logic [3*CH_IN-1:0]  rd_data,
  output logic [3*CH_OUT-1:0] src_data,
  output logic                src_valid,
  input  logic                src_ready,
  output logic                src_sop,
  output logic                src_eop,
  output logic                next_row,
  output logic                next_screen
);
  localparam int DW    = 3*CH_OUT;
  localparam int YW    = (V_RES > 1) ? $clog2(V_RES) : 1;
  localparam int BAR_W = H_RES/8;
  localparam int BW    = (BAR_W > 1) ? $clog2(BAR_W) : 1;

  localparam logic [ADDR_W-1:0] X_MAX = ADDR_W'(H_RES-1);
  localparam logic [1:0]        R_MAX = 2'(SCALE-1);
  localparam logic [YW-1:0]     Y_MAX = YW'(V_RES-1);
  localparam logic [BW-1:0]     B_MAX = BW'(BAR_W-1);

  typedef enum logic {S_IDLE, S_STREAM} state_t;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          sop;
    logic          eop;
    logic          row_end;
  } beat_t;

  state_t            r_state;
  logic              r_mode;
  logic              r_done;
  logic [ADDR_W-1:0] r_x;
  logic [1:0]        r_rx;
  logic [YW-1:0]     r_y;
  logic [1:0]        r_ry;
  logic [BW-1:0]     r_bcnt;
  logic [2:0]        r_bar;
  logic              r_p_vld;
  logic              r_p_sop;
  logic              r_p_eop;
  logic              r_p_row;
  logic [2:0]        r_p_bar;
  beat_t             r_q0;
  beat_t             r_q1;
  logic [1:0]        r_cnt;

  logic              w_pop;
  logic              w_issue;
  logic [2:0]        w_occ;
  logic              w_x_max;
  logic              w_rx_max;
  logic              w_y_max;
  logic              w_ry_max;
  logic [DW-1:0]     w_exp;
  logic [DW-1:0]     w_bars;
  beat_t             w_in;

  // MSB replication: output bit i of a channel copies input bit i mod CH_IN
  for (genvar c = 0; c < 3; c++) begin : g_ch
    for (genvar i = 0; i < CH_OUT; i++) begin : g_bit
      assign w_exp[c*CH_OUT + CH_OUT-1-i] = rd_data[c*CH_IN + CH_IN-1-(i % CH_IN)];
    end
  end

  assign w_bars = {{CH_OUT{r_p_bar[2]}}, {CH_OUT{r_p_bar[1]}}, {CH_OUT{r_p_bar[0]}}};

  assign w_in.data    = r_mode ? w_bars : w_exp;
  assign w_in.sop     = r_p_sop;
  assign w_in.eop     = r_p_eop;
  assign w_in.row_end = r_p_row;

  assign w_x_max  = (r_x == X_MAX);
  assign w_rx_max = (r_rx == R_MAX);
  assign w_y_max  = (r_y == Y_MAX);
  assign w_ry_max = (r_ry == R_MAX);

  assign src_valid = (r_cnt != 2'd0);
  assign w_pop     = src_valid & src_ready;
  // A slot freed by this cycle's pop is reusable at once: 1 pixel/cycle
  assign w_occ     = 3'(r_cnt) - 3'(w_pop) + 3'(r_p_vld);
  assign w_issue   = (r_state == S_STREAM) & ~r_done & (w_occ < 3'd2);

  assign rd_en       = w_issue & ~r_mode;
  assign rd_addr     = r_x;
  assign src_data    = r_q0.data;
  assign src_sop     = r_q0.sop;
  assign src_eop     = r_q0.eop;
  assign next_row    = w_pop & r_q0.row_end;
  assign next_screen = w_pop & r_q0.eop;

  always_ff @(posedge clock) begin
    if (!reset_reset_n) begin
      r_state <= S_IDLE;
      r_mode  <= 1'b0;
      r_done  <= 1'b0;
      r_x     <= '0;
      r_rx    <= '0;
      r_y     <= '0;
      r_ry    <= '0;
      r_bcnt  <= '0;
      r_bar   <= '0;
      r_p_vld <= 1'b0;
      r_p_sop <= 1'b0;
      r_p_eop <= 1'b0;
      r_p_row <= 1'b0;
      r_p_bar <= '0;
      r_q0    <= '0;
      r_q1    <= '0;
      r_cnt   <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (enable) begin
            r_mode  <= test_mode;
            r_done  <= 1'b0;
            r_state <= S_STREAM;
          end
        end
        S_STREAM: begin
          if (r_done && !r_p_vld && r_cnt == 2'd0) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase

      r_p_vld <= w_issue;
      if (w_issue) begin
        r_p_sop <= (r_x == '0) & (r_rx == '0) & (r_y == '0) & (r_ry == '0);
        r_p_eop <= w_x_max & w_rx_max & w_y_max & w_ry_max;
        r_p_row <= w_x_max & w_rx_max & w_ry_max;
        r_p_bar <= r_bar;
        if (w_x_max && w_rx_max && w_y_max && w_ry_max) r_done <= 1'b1;
        if (!w_rx_max) begin
          r_rx <= r_rx + 1'b1;
        end else begin
          r_rx <= '0;
          if (!w_x_max) begin
            r_x <= r_x + 1'b1;
            if (r_bcnt == B_MAX) begin
              r_bcnt <= '0;
              r_bar  <= r_bar + 1'b1;
            end else begin
              r_bcnt <= r_bcnt + 1'b1;
            end
          end else begin
            r_x    <= '0;
            r_bcnt <= '0;
            r_bar  <= '0;
            if (!w_ry_max) begin
              r_ry <= r_ry + 1'b1;
            end else begin
              r_ry <= '0;
              r_y  <= w_y_max ? '0 : r_y + 1'b1;
            end
          end
        end
      end

      if (w_pop && r_p_vld) begin
        if (r_cnt == 2'd1) begin
          r_q0 <= w_in;
        end else begin
          r_q0 <= r_q1;
          r_q1 <= w_in;
        end
      end else if (w_pop) begin
        r_q0  <= r_q1;
        r_cnt <= r_cnt - 2'd1;
      end else if (r_p_vld) begin
        if (r_cnt == 2'd0) r_q0 <= w_in;
        else               r_q1 <= w_in;
        r_cnt <= r_cnt + 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_row_streamer_param.sv
// Directed bench for row_streamer_param: 8x2 geometry at SCALE 1 and 2,
// backpressure, colour bars, channel widening, mid-frame reset and enable.
module tb_row_streamer_param;
  logic        clk;
  logic        rst_n;
  logic        en1, en2, tmode, ready, force_ff;

  logic [3:0]  a1, a2;
  logic        re1, re2;
  logic [23:0] rd1, rd2;
  logic [29:0] d1, d2;
  logic        v1, v2, sop1, sop2, eop1, eop2, nr1, nr2, ns1, ns2;

  typedef logic [33:0] beat_t;
  beat_t       q1[$], q2[$], wq[$];
  int          c1[$];
  logic [3:0]  qa1[$], qa2[$];
  int          cyc, nr1n, ns1n, re1n, v1n;
  logic        st1;
  logic [31:0] hold1;
  int          n_chk, n_err;
  int          start, vsave;

  row_streamer_param #(.CH_IN(8), .CH_OUT(10), .ADDR_W(4),
    .H_RES(8), .V_RES(2), .SCALE(1)) u_s1 (
    .clock(clk), .reset_reset_n(rst_n), .enable(en1), .test_mode(tmode),
    .rd_addr(a1), .rd_en(re1), .rd_data(rd1), .src_data(d1),
    .src_valid(v1), .src_ready(ready), .src_sop(sop1), .src_eop(eop1),
    .next_row(nr1), .next_screen(ns1));

  row_streamer_param #(.CH_IN(8), .CH_OUT(10), .ADDR_W(4),
    .H_RES(8), .V_RES(2), .SCALE(2)) u_s2 (
    .clock(clk), .reset_reset_n(rst_n), .enable(en2), .test_mode(tmode),
    .rd_addr(a2), .rd_en(re2), .rd_data(rd2), .src_data(d2),
    .src_valid(v2), .src_ready(ready), .src_sop(sop2), .src_eop(eop2),
    .next_row(nr2), .next_screen(ns2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [23:0] pat(input logic [3:0] a);
    logic [7:0] e;
    e = {4'd0, a};
    return {8'(e * 8'd37 + 8'd5), e ^ 8'hF0, {a, 4'h0}};
  endfunction

  function automatic logic [9:0] w10(input logic [7:0] c);
    return {c, c[7:6]};
  endfunction

  function automatic logic [29:0] px(input logic [3:0] a);
    logic [23:0] p;
    p = pat(a);
    return {w10(p[23:16]), w10(p[15:8]), w10(p[7:0])};
  endfunction

  function automatic logic [29:0] bars(input logic [2:0] b);
    return {{10{b[2]}}, {10{b[1]}}, {10{b[0]}}};
  endfunction

  always @(posedge clk) if (re1) rd1 <= force_ff ? 24'hFF8000 : pat(a1);
  always @(posedge clk) if (re2) rd2 <= pat(a2);

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  initial begin
    cyc = 0; st1 = 1'b0; hold1 = '0;
    nr1n = 0; ns1n = 0; re1n = 0; v1n = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (st1) chk("stall_hold", {v1, sop1, eop1, d1}, {1'b1, hold1});
      st1   = v1 && !ready;
      hold1 = {sop1, eop1, d1};
      if (v1) v1n++;
      if (v1 && ready) begin
        q1.push_back({sop1, eop1, nr1, ns1, d1});
        c1.push_back(cyc);
      end
      if (v2 && ready) q2.push_back({sop2, eop2, nr2, ns2, d2});
      if (nr1) nr1n++;
      if (ns1) ns1n++;
      if (re1) begin re1n++; qa1.push_back(a1); end
      if (re2) qa2.push_back(a2);
    end
  end

  task automatic clr();
    q1.delete(); q2.delete(); c1.delete(); qa1.delete(); qa2.delete();
    nr1n = 0; ns1n = 0; re1n = 0;
  endtask

  task automatic kick(input int which);
    if (which == 1) en1 = 1'b1;
    else            en2 = 1'b1;
    @(posedge clk); #1;
    en1 = 1'b0; en2 = 1'b0;
  endtask

  task automatic wait_beats(input int which, input int n, input int budget);
    for (int c = 0; c < budget; c++) begin
      if ((which == 1 ? q1.size() : q2.size()) >= n) break;
      @(posedge clk); #1;
    end
  endtask

  task automatic settle();
    repeat (10) @(posedge clk);
    #1;
  endtask

  task automatic check_frame(input int sc, input bit tm, input int n);
    int         x, r;
    logic [3:0] ex_f;
    logic [29:0] ex_d;
    chk("beat_count", 64'(wq.size()), 64'(n));
    for (int k = 0; k < n && k < wq.size(); k++) begin
      x = (k / sc) % 8;
      r = k / (8 * sc);
      ex_f = {k == 0, k == n-1,
              x == 7 && (k % sc) == sc-1 && (r % sc) == sc-1, k == n-1};
      ex_d = tm ? bars(3'(x)) : px(4'(x));
      chk($sformatf("beat%0d", k), 64'(wq[k]), 64'({ex_f, ex_d}));
    end
  endtask

  initial begin
    n_chk = 0; n_err = 0;
    rst_n = 1'b0; en1 = 1'b0; en2 = 1'b0;
    tmode = 1'b0; ready = 1'b1; force_ff = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_s1", {v1, re1, sop1, eop1, nr1, ns1, a1, d1}, 64'd0);
    chk("reset_s2", {v2, re2, sop2, eop2, nr2, ns2, a2, d2}, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    settle();

    clr();
    kick(1);
    start = cyc;
    wait_beats(1, 16, 200);
    settle();
    wq = q1;
    check_frame(1, 1'b0, 16);
    if (c1.size() == 16) begin
      chk("first_latency", 64'(c1[0] - start), 64'd3);
      chk("contiguous", 64'(c1[15] - c1[0]), 64'd15);
    end
    chk("next_row_cnt", 64'(nr1n), 64'd2);
    chk("next_screen_cnt", 64'(ns1n), 64'd1);

    clr();
    kick(2);
    wait_beats(2, 64, 400);
    settle();
    wq = q2;
    check_frame(2, 1'b0, 64);
    chk("addr_count_s2", 64'(qa2.size()), 64'd64);
    for (int k = 0; k < 64 && k < qa2.size(); k++)
      chk($sformatf("addr%0d", k), 64'(qa2[k]), 64'((k / 2) % 8));

    clr();
    kick(1);
    for (int c = 0; c < 600 && q1.size() < 16; c++) begin
      ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    ready = 1'b1;
    settle();
    wq = q1;
    check_frame(1, 1'b0, 16);

    clr();
    tmode = 1'b1;
    kick(1);
    wait_beats(1, 16, 200);
    settle();
    tmode = 1'b0;
    wq = q1;
    check_frame(1, 1'b1, 16);
    chk("tm_no_rd_en", 64'(re1n), 64'd0);

    clr();
    force_ff = 1'b1;
    kick(1);
    wait_beats(1, 16, 200);
    settle();
    force_ff = 1'b0;
    chk("widen_count", 64'(q1.size()), 64'd16);
    if (q1.size() > 0)
      chk("widen_ff8000", 64'(q1[0][29:0]), 64'({10'h3FF, 10'h202, 10'h000}));

    clr();
    en1 = 1'b1;
    wait_beats(1, 5, 200);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("midreset_out", {v1, re1, sop1, eop1, nr1, ns1, a1, d1}, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    clr();
    @(posedge clk); #1;
    en1 = 1'b0;
    wait_beats(1, 16, 200);
    settle();
    wq = q1;
    check_frame(1, 1'b0, 16);
    if (qa1.size() > 0) chk("restart_addr0", 64'(qa1[0]), 64'd0);

    clr();
    en1 = 1'b1;
    wait_beats(1, 3, 200);
    en1 = 1'b0;
    wait_beats(1, 16, 200);
    settle();
    wq = q1;
    check_frame(1, 1'b0, 16);
    chk("drop_screen", 64'(ns1n), 64'd1);
    vsave = v1n;
    repeat (20) @(posedge clk);
    #1;
    chk("idle_no_valid", 64'(v1n), 64'(vsave));
    clr();
    en1 = 1'b1;
    for (int c = 0; c < 20 && v1n == vsave; c++) begin
      @(posedge clk); #1;
    end
    en1 = 1'b0;
    chk("reenable_valid", 64'(v1n > vsave), 64'd1);
    wait_beats(1, 16, 200);
    settle();
    wq = q1;
    check_frame(1, 1'b0, 16);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule
